// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline definitions for the write-back stage.
// Holds the result-source encodings, the load funct3 constants and the
// datapath / register-index widths. There are no ports: this is a package.
package rv_pkg;

    localparam int RV_XLEN = 32;
    localparam int REG_W   = 5;

    // Result source selected in write-back
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wb_sel_e;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: picks the byte/half/word addressed by the low
// address bits out of an aligned memory word and sign- or zero-extends it.
// Ports:
//   i_raw     in  32  aligned word from data memory
//   i_funct3  in  3   load type
//   i_addr_lo in  2   low address bits of the load
//   o_data    out 32  extended load value
//   o_fault   out 1   misaligned access or unsupported funct3
module load_extend
    import rv_pkg::*;
(
    input  logic [RV_XLEN-1:0] i_raw,
    input  logic [2:0]         i_funct3,
    input  logic [1:0]         i_addr_lo,
    output logic [RV_XLEN-1:0] o_data,
    output logic               o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte and half-word lane selection
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_raw[7:0];
            2'd1:    w_byte = i_raw[15:8];
            2'd2:    w_byte = i_raw[23:16];
            2'd3:    w_byte = i_raw[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_raw[31:16];
        end else begin
            w_half = i_raw[15:0];
        end
    end

    // Extension and alignment check by load type
    always_comb begin
        o_data  = 32'h0000_0000;
        o_fault = 1'b0;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_data = {24'h00_0000, w_byte};
            F3_LH: begin
                o_data  = {{16{w_half[15]}}, w_half};
                o_fault = i_addr_lo[0];
            end
            F3_LHU: begin
                o_data  = {16'h0000, w_half};
                o_fault = i_addr_lo[0];
            end
            F3_LW: begin
                o_data  = i_raw;
                o_fault = (i_addr_lo != 2'b00);
            end
            default: begin
                // 011, 110, 111 are not RV32I loads
                o_data  = 32'h0000_0000;
                o_fault = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the result, commits it to the 32x32 integer
// register file, serves the two decode read ports with write-through bypass,
// and drives a registered forwarding bundle, a retire counter and a sticky
// load-fault flag.
// Ports:
//   clk, reset (sync, active-high)
//   wb_*                 MEM/WB bundle (valid, reg_write, rd, sel, operands,
//                        funct3, addr_lo)
//   rs1/rs2_addr, _data  combinational decode read ports
//   fwd_valid/rd/data    registered copy of last cycle's committed write
//   retire_count         valid instructions retired (wraps)
//   err_sticky, err_rd   first faulting load and its destination
module wb_regfile_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [1:0]       wb_sel,
    input  logic [XLEN-1:0]  wb_alu_result,
    input  logic [XLEN-1:0]  wb_load_data,
    input  logic [XLEN-1:0]  wb_pc_plus4,
    input  logic [XLEN-1:0]  wb_imm,
    input  logic [2:0]       wb_funct3,
    input  logic [1:0]       wb_addr_lo,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] retire_count,
    output logic             err_sticky,
    output logic [4:0]       err_rd
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic             r_fwd_valid;
    logic [4:0]       r_fwd_rd;
    logic [XLEN-1:0]  r_fwd_data;
    logic [CNT_W-1:0] r_retire_count;
    logic             r_err_sticky;
    logic [4:0]       r_err_rd;

    logic [XLEN-1:0]  w_load_ext;
    logic             w_ext_fault;
    logic             w_fault;
    logic             w_we;
    logic [XLEN-1:0]  w_wb_data;

    load_extend u_load_extend (
        .i_raw     (wb_load_data),
        .i_funct3  (wb_funct3),
        .i_addr_lo (wb_addr_lo),
        .o_data    (w_load_ext),
        .o_fault   (w_ext_fault)
    );

    // Result source selection
    always_comb begin
        w_wb_data = wb_alu_result;
        case (wb_sel)
            WB_ALU:  w_wb_data = wb_alu_result;
            WB_LOAD: w_wb_data = w_load_ext;
            WB_PC4:  w_wb_data = wb_pc_plus4;
            WB_IMM:  w_wb_data = wb_imm;
            default: w_wb_data = wb_alu_result;
        endcase
    end

    // Only real load slots can fault; reset also gates the bypass so a
    // discarded write is never visible on the read ports.
    assign w_fault = wb_valid & (wb_sel == WB_LOAD) & w_ext_fault;
    assign w_we    = ~reset & wb_valid & wb_reg_write & (wb_rd != 5'd0) & ~w_fault;

    // Read port 1 with write-through bypass
    always_comb begin
        if (rs1_addr == 5'd0) begin
            rs1_data = {XLEN{1'b0}};
        end else if (w_we && (rs1_addr == wb_rd)) begin
            rs1_data = w_wb_data;
        end else begin
            rs1_data = r_regs[rs1_addr];
        end
    end

    // Read port 2 with write-through bypass
    always_comb begin
        if (rs2_addr == 5'd0) begin
            rs2_data = {XLEN{1'b0}};
        end else if (w_we && (rs2_addr == wb_rd)) begin
            rs2_data = w_wb_data;
        end else begin
            rs2_data = r_regs[rs2_addr];
        end
    end

    // Register file commit, forwarding bundle, retire count and fault capture
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
            r_fwd_valid    <= 1'b0;
            r_fwd_rd       <= 5'd0;
            r_fwd_data     <= {XLEN{1'b0}};
            r_retire_count <= {CNT_W{1'b0}};
            r_err_sticky   <= 1'b0;
            r_err_rd       <= 5'd0;
        end else begin
            if (w_we) begin
                r_regs[wb_rd] <= w_wb_data;
            end
            r_fwd_valid <= w_we;
            r_fwd_rd    <= w_we ? wb_rd : 5'd0;
            r_fwd_data  <= w_we ? w_wb_data : {XLEN{1'b0}};
            if (wb_valid) begin
                r_retire_count <= r_retire_count + CNT_W'(1);
            end
            if (w_fault) begin
                r_err_sticky <= 1'b1;
                // First fault wins
                if (!r_err_sticky) begin
                    r_err_rd <= wb_rd;
                end
            end
        end
    end

    assign fwd_valid    = r_fwd_valid;
    assign fwd_rd       = r_fwd_rd;
    assign fwd_data     = r_fwd_data;
    assign retire_count = r_retire_count;
    assign err_sticky   = r_err_sticky;
    assign err_rd       = r_err_rd;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed self-checking bench for wb_regfile_stage. A second instance with a
// 4-bit retire counter, fed the same stimulus, exercises counter wrap.
module tb_wb_regfile_stage;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_load_data;
    logic [31:0] wb_pc_plus4;
    logic [31:0] wb_imm;
    logic [2:0]  wb_funct3;
    logic [1:0]  wb_addr_lo;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [31:0] retire_count;
    logic        err_sticky;
    logic [4:0]  err_rd;

    logic [31:0] n_rs1_data;
    logic [31:0] n_rs2_data;
    logic        n_fwd_valid;
    logic [4:0]  n_fwd_rd;
    logic [31:0] n_fwd_data;
    logic [3:0]  n_retire_count;
    logic        n_err_sticky;
    logic [4:0]  n_err_rd;

    int checks_r = 0;
    int errors_r = 0;

    wb_regfile_stage dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_alu_result(wb_alu_result),
        .wb_load_data(wb_load_data), .wb_pc_plus4(wb_pc_plus4), .wb_imm(wb_imm),
        .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_count(retire_count), .err_sticky(err_sticky), .err_rd(err_rd)
    );

    wb_regfile_stage #(.CNT_W(4)) dut_narrow (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_alu_result(wb_alu_result),
        .wb_load_data(wb_load_data), .wb_pc_plus4(wb_pc_plus4), .wb_imm(wb_imm),
        .wb_funct3(wb_funct3), .wb_addr_lo(wb_addr_lo), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(n_rs1_data), .rs2_data(n_rs2_data),
        .fwd_valid(n_fwd_valid), .fwd_rd(n_fwd_rd), .fwd_data(n_fwd_data),
        .retire_count(n_retire_count), .err_sticky(n_err_sticky), .err_rd(n_err_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r++;
        if (got !== exp) begin
            errors_r++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one slot; sel 0=ALU 1=LOAD
    task automatic slot(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [2:0] f3, input logic [1:0] alo);
        wb_valid      = v;
        wb_reg_write  = rw;
        wb_rd         = rd;
        wb_sel        = sel;
        wb_alu_result = alu;
        wb_funct3     = f3;
        wb_addr_lo    = alo;
        #1;
    endtask

    // Clock edge, then drop the slot so reads come from the array
    task automatic tick();
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0;
        wb_sel = 2'b00; wb_alu_result = 32'h0; wb_load_data = 32'h80FF_7F01;
        wb_pc_plus4 = 32'h0000_1004; wb_imm = 32'h1234_5000;
        wb_funct3 = 3'b000; wb_addr_lo = 2'b00; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        rs1_addr = 5'd5;
        #1;
        check_val("rst_rs1", rs1_data, 32'h0);
        check_val("rst_fwd_valid", {31'd0, fwd_valid}, 32'h0);
        check_val("rst_count", retire_count, 32'h0);
        check_val("rst_err", {31'd0, err_sticky}, 32'h0);

        // Write with same-cycle bypass on both ports
        rs2_addr = 5'd5;
        slot(1'b1, 1'b1, 5'd5, 2'b00, 32'hDEAD_BEEF, 3'b000, 2'b00);
        check_val("bypass_rs1", rs1_data, 32'hDEAD_BEEF);
        check_val("bypass_rs2", rs2_data, 32'hDEAD_BEEF);
        tick();
        check_val("array_rs1", rs1_data, 32'hDEAD_BEEF);
        check_val("fwd_valid1", {31'd0, fwd_valid}, 32'h1);
        check_val("fwd_rd1", {27'd0, fwd_rd}, 32'd5);
        check_val("fwd_data1", fwd_data, 32'hDEAD_BEEF);
        check_val("count1", retire_count, 32'd1);

        // x0 protection
        rs1_addr = 5'd0;
        slot(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_1234, 3'b000, 2'b00);
        check_val("x0_bypass", rs1_data, 32'h0);
        tick();
        check_val("x0_read", rs1_data, 32'h0);
        check_val("x0_fwd_valid", {31'd0, fwd_valid}, 32'h0);
        check_val("x0_fwd_data", fwd_data, 32'h0);
        check_val("x0_count", retire_count, 32'd2);

        // Load extension on 0x80FF7F01
        slot(1'b1, 1'b1, 5'd7, 2'b01, 32'h0, 3'b000, 2'd1); tick();
        slot(1'b1, 1'b1, 5'd8, 2'b01, 32'h0, 3'b000, 2'd3); tick();
        slot(1'b1, 1'b1, 5'd10, 2'b01, 32'h0, 3'b101, 2'd2); tick();
        slot(1'b1, 1'b1, 5'd11, 2'b01, 32'h0, 3'b001, 2'd2); tick();
        slot(1'b1, 1'b1, 5'd12, 2'b01, 32'h0, 3'b100, 2'd3); tick();
        rs1_addr = 5'd7;  rs2_addr = 5'd8; #1;
        check_val("lb_a1", rs1_data, 32'h0000_007F);
        check_val("lb_a3", rs2_data, 32'hFFFF_FF80);
        rs1_addr = 5'd10; rs2_addr = 5'd11; #1;
        check_val("lhu_a2", rs1_data, 32'h0000_80FF);
        check_val("lh_a2", rs2_data, 32'hFFFF_80FF);
        rs1_addr = 5'd12; #1;
        check_val("lbu_a3", rs1_data, 32'h0000_0080);
        check_val("count_loads", retire_count, 32'd7);

        // Faults: preload x9, then misaligned LW
        slot(1'b1, 1'b1, 5'd9, 2'b00, 32'h0000_0099, 3'b000, 2'b00); tick();
        rs1_addr = 5'd9;
        slot(1'b1, 1'b1, 5'd9, 2'b01, 32'h0, 3'b010, 2'd2);
        check_val("fault_nobypass", rs1_data, 32'h0000_0099);
        tick();
        check_val("fault_x9", rs1_data, 32'h0000_0099);
        check_val("fault_sticky", {31'd0, err_sticky}, 32'h1);
        check_val("fault_rd", {27'd0, err_rd}, 32'd9);
        check_val("fault_fwd", {31'd0, fwd_valid}, 32'h0);
        check_val("fault_count", retire_count, 32'd9);
        slot(1'b1, 1'b1, 5'd4, 2'b01, 32'h0, 3'b001, 2'd1); tick();
        check_val("fault2_rd", {27'd0, err_rd}, 32'd9);
        rs1_addr = 5'd4; #1;
        check_val("fault2_x4", rs1_data, 32'h0);
        slot(1'b1, 1'b1, 5'd12, 2'b01, 32'h0, 3'b110, 2'd0); tick();
        rs1_addr = 5'd12; #1;
        check_val("f3_110_x12", rs1_data, 32'h0000_0080);
        check_val("fault3_sticky", {31'd0, err_sticky}, 32'h1);
        slot(1'b1, 1'b1, 5'd13, 2'b01, 32'h0, 3'b010, 2'd0); tick();
        rs1_addr = 5'd13; #1;
        check_val("lw_a0", rs1_data, 32'h80FF_7F01);
        check_val("count12", retire_count, 32'd12);

        // Bubbles: no count change, no write
        for (int i = 0; i < 3; i++) begin
            slot(1'b0, 1'b1, 5'd13, 2'b00, 32'h0000_5555, 3'b000, 2'b00);
            tick();
        end
        check_val("bubble_x13", rs1_data, 32'h80FF_7F01);
        check_val("bubble_count", retire_count, 32'd12);
        check_val("bubble_fwd", {31'd0, fwd_valid}, 32'h0);

        // Wrap of the 4-bit counter: 12 -> 15 -> 0
        for (int i = 0; i < 3; i++) begin
            slot(1'b1, 1'b1, 5'd14, 2'b11, 32'h0, 3'b000, 2'b00);
            tick();
        end
        check_val("narrow_15", {28'd0, n_retire_count}, 32'd15);
        rs1_addr = 5'd14; #1;
        check_val("imm_x14", rs1_data, 32'h1234_5000);
        slot(1'b1, 1'b1, 5'd15, 2'b10, 32'h0, 3'b000, 2'b00); tick();
        check_val("narrow_wrap", {28'd0, n_retire_count}, 32'd0);
        check_val("count16", retire_count, 32'd16);
        rs1_addr = 5'd15; #1;
        check_val("pc4_x15", rs1_data, 32'h0000_1004);

        // Reset in the same cycle as a valid write
        rs1_addr = 5'd3; rs2_addr = 5'd5;
        reset = 1'b1;
        slot(1'b1, 1'b1, 5'd3, 2'b00, 32'h0000_0033, 3'b000, 2'b00);
        tick();
        reset = 1'b0;
        #1;
        check_val("rst_x3", rs1_data, 32'h0);
        check_val("rst_x5", rs2_data, 32'h0);
        check_val("rst_count2", retire_count, 32'h0);
        check_val("rst_err2", {31'd0, err_sticky}, 32'h0);
        check_val("rst_errrd2", {27'd0, err_rd}, 32'h0);
        check_val("rst_fwd2", {31'd0, fwd_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Write-back end of the 5-stage RISC-V pipeline. Consumes the bundle held in the MEM/WB pipeline register.
- Selects the result source and sign/zero-extends load data by funct3 and byte offset.
- Commits the result into the 32x32 integer register file and serves the two decode-stage read ports with same-cycle write-through bypass.
- Drives a registered forwarding bundle back toward EX and keeps a retire counter plus a sticky error flag.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, number of architectural registers (x0 hard-wired zero)
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- wb_valid  in  1  MEM/WB slot holds a real instruction (0 = bubble)
- wb_reg_write  in  1  instruction writes rd
- wb_rd  in  5  destination register
- wb_sel  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
- wb_alu_result  in  XLEN  ALU result
- wb_load_data  in  XLEN  raw aligned word from data memory
- wb_pc_plus4  in  XLEN  link value
- wb_imm  in  XLEN  U-type immediate
- wb_funct3  in  3  load type
- wb_addr_lo  in  2  low address bits of the load
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_data, rs2_data  out  XLEN each  read data (combinational)
- fwd_valid  out  1  registered: a register write committed last cycle
- fwd_rd  out  5  registered destination of that write
- fwd_data  out  XLEN  registered value of that write
- retire_count  out  CNT_W  valid instructions retired
- err_sticky  out  1  illegal/misaligned load seen
- err_rd  out  5  rd of the first faulting load

Behaviour:
- Reset (synchronous, active-high): all registers, fwd_*, retire_count, err_sticky and err_rd clear to 0 on the edge. Any write presented in a reset cycle is discarded. rs*_data read 0 while the file is cleared.
- Load extraction (wb_sel=01):
  - 000 LB: sign-extend byte[addr_lo].
  - 100 LBU: zero-extend byte[addr_lo].
  - 001 LH / 101 LHU: half selected by addr_lo[1], sign- or zero-extended.
  - 010 LW: full word.
- Load faults: a load faults when any of these holds:
  - LH/LHU with addr_lo[0]=1
  - LW with addr_lo!=0
  - funct3 is 011, 110 or 111
- On a fault:
  - The write is suppressed.
  - err_sticky is set.
  - err_rd captures wb_rd, but only if err_sticky was 0 (first fault wins).
  - err_sticky clears only on reset.
- Commit condition: we = wb_valid & wb_reg_write & (wb_rd!=0) & ~fault. On a clock edge with we, regs[wb_rd] <= wb_data. Single-cycle latency; no stalls, no handshake. Every valid slot retires.
- x0: writes are ignored, reads always return 0.
- Read ports: combinational.
  - If rsN_addr==0, return 0.
  - Else if we and rsN_addr==wb_rd, return wb_data (write-through bypass).
  - Else return regs[rsN_addr].
  - Both ports may hit the same register in the same cycle.
- Forwarding register: updated every edge.
  - fwd_valid <= we
  - fwd_rd <= we ? wb_rd : 0
  - fwd_data <= we ? wb_data : 0
- retire_count: increments on every edge with wb_valid=1, including suppressed and faulting instructions. Wraps modulo 2^CNT_W. Bubbles do not count.
- Simultaneous events: reset overrides commit, error capture and count in the same cycle. A faulting load still increments retire_count.

Decomposition:
- Shared package rv_pkg holds:
  - wb_sel encodings (WB_ALU, WB_LOAD, WB_PC4, WB_IMM)
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - XLEN and register-index width
- Natural sub-module: load_extend, purely combinational. Inputs raw word, funct3, addr_lo; outputs extended value and fault.
- The register file array stays inline in this block.

Test Plan:
- Reset then write: reset for 2 cycles, then wb_valid=1, reg_write=1, rd=5, sel=00, alu=0xDEADBEEF. Required: rs1_addr=5 reads 0xDEADBEEF in the same cycle via bypass and after the edge from the array; fwd_valid=1, fwd_rd=5 one cycle later; retire_count=1.
- x0 protection: write rd=0 with alu=0x1234. Required: rs1_addr=0 reads 0, fwd_valid=0, retire_count still increments.
- Load extension: raw=0x80FF7F01, addr_lo=1, LB. Required: x7=0x0000007F. Same word with addr_lo=3, LB: 0xFFFFFF80. addr_lo=2, LHU: 0x000080FF. addr_lo=2, LH: 0xFFFF80FF.
- Faults: LW with addr_lo=2, rd=9. Required: x9 unchanged, err_sticky=1, err_rd=9. A second fault with rd=4 leaves err_rd=9. funct3=110 is also suppressed.
- Bubbles and wrap: preload retire_count to 0xFFFFFFFF via 2^32-1 valid slots (or a forced start value). Required: the next valid slot makes it 0. Interleaved wb_valid=0 cycles cause no count change and no writes.
- Reset mid-stream: assert reset in the same cycle as a valid write to rd=3. Required: x3=0, retire_count=0, err_sticky=0, fwd_valid=0 after the edge.
